// File: rtl/vc16_ifetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc16_ifetch_if : fetch-unit bus (control, instruction memory, decoder side)
// Revision 1.0
// ---------------------------------------------------------------------------
interface vc16_ifetch_if #(
  parameter int RV = 32
);
  logic          stall;
  logic          redirect;
  logic [RV-1:0] redirect_pc;
  logic          mem_req;
  logic [RV-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          mem_fault;
  logic [15:0]   ins;
  logic          idone;
  logic [RV-1:0] ins_pc;
  logic          ins_fault;

  modport master (
    input  stall, redirect, redirect_pc, mem_ack, mem_rdata, mem_fault,
    output mem_req, mem_addr, ins, idone, ins_pc, ins_fault
  );

  modport slave (
    output stall, redirect, redirect_pc, mem_ack, mem_rdata, mem_fault,
    input  mem_req, mem_addr, ins, idone, ins_pc, ins_fault
  );
endinterface
`default_nettype wire

// File: rtl/vc16_ifetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc16_ifetch : 32-bit word fetch, split into 16-bit instructions with PC tag
// Revision 1.0
// ---------------------------------------------------------------------------
module vc16_ifetch #(
  parameter int            RV       = 32,
  parameter logic [RV-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  vc16_ifetch_if.master   bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [RV-1:0] r_pc;
  logic [31:0]   r_buf;
  logic          r_buf_vld;
  logic          r_buf_fault;
  logic          r_mem_req;
  logic [RV-1:0] r_mem_addr;
  logic [15:0]   r_ins;
  logic [RV-1:0] r_ins_pc;
  logic          r_ins_fault;

  logic          w_issue;
  logic [15:0]   w_half;
  logic [15:0]   w_ins;
  logic [RV-1:0] w_pc_inc;
  logic [RV-1:0] w_redir_pc;

  assign w_half     = r_pc[1] ? r_buf[31:16] : r_buf[15:0];
  // A faulting fetch delivers all-zero, which the decoder treats as a trap.
  assign w_ins      = r_buf_fault ? 16'h0000 : w_half;
  assign w_pc_inc   = r_pc + {{(RV-2){1'b0}}, 2'b10};
  assign w_redir_pc = bus.redirect_pc & ~{{(RV-1){1'b0}}, 1'b1};
  assign w_issue    = reset && (r_state == S_ISSUE) && r_buf_vld
                      && !bus.stall && !bus.redirect;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_buf       <= '0;
      r_buf_vld   <= 1'b0;
      r_buf_fault <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= {RESET_PC[RV-1:2], 2'b00};
      r_ins       <= '0;
      r_ins_pc    <= RESET_PC;
      r_ins_fault <= 1'b0;
    end else if (bus.redirect) begin
      r_pc        <= w_redir_pc;
      r_buf_vld   <= 1'b0;
      r_buf_fault <= 1'b0;
      // An unacknowledged request must finish before the new target is fetched.
      if (r_mem_req && !bus.mem_ack) begin
        r_state <= S_DRAIN;
      end else begin
        r_state    <= S_FETCH;
        r_mem_req  <= 1'b1;
        r_mem_addr <= {w_redir_pc[RV-1:2], 2'b00};
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (r_mem_req && bus.mem_ack) begin
            r_buf       <= bus.mem_rdata;
            r_buf_fault <= bus.mem_fault;
            r_buf_vld   <= 1'b1;
            r_mem_req   <= 1'b0;
            r_state     <= S_ISSUE;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_pc[RV-1:2], 2'b00};
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_ins       <= w_ins;
            r_ins_pc    <= r_pc;
            r_ins_fault <= r_buf_fault;
            if (r_buf_fault) begin
              r_buf_vld <= 1'b0;
              r_state   <= S_HALT;
            end else begin
              r_pc <= w_pc_inc;
              if (r_pc[1]) begin
                r_buf_vld  <= 1'b0;
                r_state    <= S_FETCH;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {w_pc_inc[RV-1:2], 2'b00};
              end
            end
          end
        end
        S_DRAIN: begin
          if (bus.mem_ack) begin
            r_state    <= S_FETCH;
            r_mem_addr <= {r_pc[RV-1:2], 2'b00};
          end
        end
        S_HALT: begin
          r_mem_req <= 1'b0;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.idone     = w_issue;
  assign bus.ins       = w_issue ? w_ins       : r_ins;
  assign bus.ins_pc    = w_issue ? r_pc        : r_ins_pc;
  assign bus.ins_fault = w_issue ? r_buf_fault : r_ins_fault;

endmodule
`default_nettype wire

// File: doc/vc16_ifetch.md
Name: vc16_ifetch

Overview:
- Instruction fetch unit for the VC16 16-bit-instruction core; the producer side of the decoder's `ins`/`idone` interface.
- Fetches 32-bit little-endian words from the instruction memory port and splits them into 16-bit instructions.
- Presents one instruction per `idone` pulse, tagged with its PC, and handles branch/jump redirects and fetch faults.

Parameters:
- RV, 32, address/PC width in bits.
- RESET_PC, 0, PC of the first instruction after reset; bit 0 must be 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = in reset).
- stall  in  1  downstream not ready; no `idone` is issued while high.
- redirect  in  1  one-cycle strobe: a taken branch/jump/trap vector.
- redirect_pc  in  RV  new PC, sampled when `redirect`=1; bit 0 ignored (treated as 0).
- mem_req  out  1  word fetch request.
- mem_addr  out  RV  word address; bits [1:0] are always 0.
- mem_ack  in  1  request complete; `mem_rdata`/`mem_fault` are valid this cycle.
- mem_rdata  in  32  fetched word; halfword at addr+0 is [15:0], at addr+2 is [31:16].
- mem_fault  in  1  fetch error, qualified by `mem_ack`.
- ins  out  16  instruction, valid when `idone`=1.
- idone  out  1  one-cycle pulse; one pulse per delivered instruction.
- ins_pc  out  RV  PC of `ins`.
- ins_fault  out  1  delivered instruction came from a faulting fetch.

Behaviour:
- Internal state:
  - fetch PC `pc`, modulo 2^RV, step 2.
  - 32-bit word buffer with valid bit.
  - FSM states: FETCH, ISSUE, DRAIN, HALT.
- Reset (reset=0 at a clock edge):
  - Outputs: `mem_req`=0, `idone`=0, `ins`=0, `ins_fault`=0.
  - `ins_pc`=RESET_PC; `mem_addr`={RESET_PC[RV-1:2],2'b00}.
  - `pc`=RESET_PC, buffer invalid, state FETCH.
  - Reset overrides every other input, including mid-request. A memory ack arriving during or after reset for an earlier request is ignored.
- FETCH:
  - `mem_req`=1, `mem_addr`={pc[RV-1:2],2'b00}.
  - Both held stable until `mem_ack`.
  - `mem_req` is registered; first assertion is the cycle after `reset` goes high.
  - On ack with `mem_fault`=0: load the buffer and go to ISSUE.
  - On ack with `mem_fault`=1: go to ISSUE with a fault-marked buffer.
- ISSUE:
  - Selected halfword is `pc[1]` ? buf[31:16] : buf[15:0].
  - If `stall`=0 and `redirect`=0:
    - `idone`=1, `ins`=selected halfword, `ins_pc`=pc, `ins_fault`=0.
    - Then pc+=2.
    - If pc[1] was 1 (word exhausted), go to FETCH the next cycle; otherwise stay in ISSUE.
    - Back-to-back `idone` in consecutive cycles is legal for both halves of a word.
  - Latency: `mem_ack` in cycle N gives the earliest `idone` in N+1.
  - Upper-half-to-lower-half bubble:
    - pc[1]=1 issue in cycle M, then FETCH/`mem_req` in M+1.
    - Zero-wait memory ack in M+1 gives the next `idone` in M+2.
  - Fault buffer:
    - Issues exactly one `idone` with `ins`=16'h0000 (decodes as trap), `ins_fault`=1, `ins_pc`=pc.
    - Then goes to HALT.
- HALT: `mem_req`=0, no `idone`; leaves only on `redirect`.
- `ins`, `ins_pc` and `ins_fault` hold their last values when `idone`=0.
- Redirect (any state):
  - Highest priority after reset. `idone` is forced 0 that cycle.
  - Effects: `pc`=redirect_pc & ~1, buffer invalidated.
  - If `mem_req`=1 and `mem_ack`=0 this cycle: go to DRAIN.
  - Otherwise (including when ack arrives the same cycle; that data is discarded): go to FETCH.
  - First `mem_req` for the new target appears next cycle.
- DRAIN:
  - Keep `mem_req`/`mem_addr` of the outstanding request stable until `mem_ack`.
  - Discard that data and fault, then go to FETCH at the redirected pc.
  - A further `redirect` in DRAIN updates `pc` and stays in DRAIN.
- Unaligned target (redirect_pc[1]=1): fetch the containing word; issue only the upper half, then fetch the next word.
- `stall` never affects `mem_req`; a fetch completes while stalled and the buffer holds until `stall`=0.
- PC wrap: pc=2^RV-2 issues, then pc=0 and `mem_addr`=0.

Test Plan:
- Reset release, RESET_PC=0x100, 1-cycle ack, `mem_rdata`=0x1234_5678, stall=0:
  - `mem_addr`=0x100.
  - `idone` with `ins`=0x5678 @ `ins_pc`=0x100, next cycle `ins`=0x1234 @ 0x102.
  - Then `mem_addr`=0x104.
- Stall held high 5 cycles after ack → no `idone`; on release, `ins`=0x5678 issues the following cycle with the buffer intact.
- Redirect to 0x206 while a request to 0x104 is outstanding with ack delayed 3 cycles:
  - `mem_addr` stays 0x104 until ack; data discarded.
  - Then `mem_addr`=0x204; single `idone` with `ins`=rdata[31:16] @ 0x206.
  - Then `mem_addr`=0x208.
- Redirect in the same cycle as `mem_ack` and a pending `idone` → no `idone`; next cycle `mem_req` with the redirect target.
- `mem_ack` with `mem_fault`=1 at 0x300:
  - One `idone`, `ins`=0x0000, `ins_fault`=1, `ins_pc`=0x300.
  - `mem_req` stays 0 until redirect to 0x0.
- Reset asserted mid-request (`mem_req`=1, no ack) → next cycle `mem_req`=0, `idone`=0; after release, fetch restarts at RESET_PC.
